// File: rtl/prog_loader.sv
// prog_loader: packs a big-endian byte stream into 32-bit words, writes them to instruction memory, then runs the processor
//   clock, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready    : byte-stream handshake; a byte is taken when both are high
//   in_byte, in_last      : program byte (first byte of a word is its MSB), final-byte marker
//   start                 : re-arms the loader from DONE
//   addr, wr, wdata       : instruction-memory write port
//   working, done, err    : run enable, run finished, load overflowed without in_last
//   word_count            : words written in the current load
module prog_loader #(
    parameter int MAX_WORDS  = 256,
    parameter int RUN_CYCLES = 28,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             start,
    output logic [31:0]      addr,
    output logic             wr,
    output logic [31:0]      wdata,
    output logic             working,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);
    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [CNT_W-1:0] WC_MAX   = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      asm_q, asm_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [31:0]      addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             working_q, working_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      byte_word;
    logic [CNT_W-1:0] wc_inc;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        run_d        = run_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        working_d    = working_q;
        done_d       = done_q;
        err_d        = err_q;
        // incoming byte lands in the slot selected by the byte index; unfilled slots stay zero
        byte_word    = asm_q | ({in_byte, 24'h0} >> {idx_q, 3'b000});
        wc_inc       = word_count_q + CNT_W'(1);
        case (state_q)
            S_LOAD: if (in_valid) begin
                idx_d = idx_q + 2'd1;
                asm_d = byte_word;
                if (idx_q == 2'd3 || in_last) begin
                    state_d = S_WRITE;
                    wr_d    = 1'b1;
                    addr_d  = 32'(word_count_q);
                    wdata_d = byte_word;
                    last_d  = in_last;
                end
            end
            S_WRITE: begin
                word_count_d = wc_inc;
                idx_d        = 2'd0;
                asm_d        = 32'h0;
                wr_d         = 1'b0;
                addr_d       = 32'h0;
                wdata_d      = 32'h0;
                state_d      = (last_q || wc_inc == WC_MAX) ? S_SETTLE : S_LOAD;
                err_d        = err_q | (wc_inc == WC_MAX && !last_q);
            end
            S_SETTLE: begin
                state_d   = S_RUN;
                run_d     = '0;
                working_d = 1'b1;
            end
            S_RUN: begin
                run_d = run_q + CNT_W'(1);
                if (run_q == RUN_LAST) begin
                    state_d   = S_DONE;
                    working_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            S_DONE: if (start) begin
                state_d      = S_LOAD;
                word_count_d = '0;
                done_d       = 1'b0;
                err_d        = 1'b0;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            idx_q        <= 2'd0;
            asm_q        <= 32'h0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            run_q        <= '0;
            addr_q       <= 32'h0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'h0;
            working_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            run_q        <= run_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            working_q    <= working_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = state_q == S_LOAD;
    assign addr       = addr_q;
    assign wr         = wr_q;
    assign wdata      = wdata_q;
    assign working    = working_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;
endmodule
